draw_shot: RTL

- Sprite responder for the entity draw handshake, occupying the D_SHOT slot (index 0) of the draw mux.
- On a `plot` request it latches the shot position. It erases the shot's previously drawn square in the background colour, then draws the new square in the shot colour.
- It emits one pixel per cycle on x/y/color/writeEn, then pulses `draw_done`.
- It keeps the last drawn position internally so the upstream controller only ever supplies the new position.

---
 rtl/draw_pkg.sv | 22 ++
 rtl/draw_shot_if.sv | 24 ++
 rtl/block_scanner.sv | 41 ++++
 rtl/draw_shot.sv | 114 +++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared constants, draw-mux codes and draw FSM state type
package draw_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] COL_BG   = 3'b000;
    localparam logic [2:0] COL_SHOT = 3'b111;

    // One-hot slot codes of the entity draw mux
    localparam logic [2:0] D_SHIP     = 3'b100;
    localparam logic [2:0] D_ASTEROID = 3'b010;
    localparam logic [2:0] D_SHOT     = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ERASE,
        S_DRAW,
        S_DONE
    } draw_state_t;

endpackage

// File: rtl/draw_shot_if.sv
// rtl/draw_shot_if.sv - entity draw handshake: job request in, pixel stream and done out
interface draw_shot_if;

    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic       alive;
    logic       plot;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] color;
    logic       writeEn;
    logic       draw_done;

    modport master (
        output x_pos, y_pos, alive, plot,
        input  x, y, color, writeEn, draw_done
    );

    modport slave (
        input  x_pos, y_pos, alive, plot,
        output x, y, color, writeEn, draw_done
    );

endinterface

// File: rtl/block_scanner.sv
// rtl/block_scanner.sv - SIZE x SIZE row-major pixel counter shared by the sprite drawers
module block_scanner #(
    parameter int SIZE = 2,
    parameter int CW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic          step_i,
    output logic [CW-1:0] cx_o,
    output logic [CW-1:0] cy_o,
    output logic          last_o
);

    localparam logic [CW-1:0] MAX_C = CW'(SIZE - 1);

    logic [CW-1:0] cx_q;
    logic [CW-1:0] cy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cx_q <= '0;
            cy_q <= '0;
        end else if (start_i) begin
            cx_q <= '0;
            cy_q <= '0;
        end else if (step_i) begin
            if (cx_q == MAX_C) begin
                cx_q <= '0;
                cy_q <= (cy_q == MAX_C) ? '0 : cy_q + CW'(1);
            end else begin
                cx_q <= cx_q + CW'(1);
            end
        end
    end

    assign cx_o   = cx_q;
    assign cy_o   = cy_q;
    assign last_o = (cx_q == MAX_C) && (cy_q == MAX_C);

endmodule

// File: rtl/draw_shot.sv
// rtl/draw_shot.sv - shot sprite responder: erase previous square, draw new one, pulse draw_done
module draw_shot #(
    parameter int         SIZE       = 2,
    parameter int         SCREEN_W   = draw_pkg::SCREEN_W,
    parameter int         SCREEN_H   = draw_pkg::SCREEN_H,
    parameter logic [2:0] SHOT_COLOR = draw_pkg::COL_SHOT,
    parameter logic [2:0] BG_COLOR   = draw_pkg::COL_BG
) (
    input  logic        clk,
    input  logic        reset,
    draw_shot_if.slave  bus
);

    import draw_pkg::*;

    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

    draw_state_t   state_q;
    logic [9:0]    lat_x_q, lat_y_q, prev_x_q, prev_y_q;
    logic          lat_alive_q, prev_valid_q;
    logic [9:0]    x_q, y_q;
    logic [2:0]    color_q;
    logic          we_q, done_q;

    logic [CW-1:0] cx, cy;
    logic          last;
    logic          scan_step, scan_start;
    logic [9:0]    base_x, base_y;
    logic [10:0]   sum_x, sum_y;
    logic          visible;

    // Counter restarts whenever a phase is not running or one just finished,
    // so the next phase always begins at (0,0) with no gap cycle.
    assign scan_step  = (state_q == S_ERASE) || (state_q == S_DRAW);
    assign scan_start = !scan_step || last;

    block_scanner #(.SIZE(SIZE), .CW(CW)) u_scan (
        .clk     (clk),
        .reset   (reset),
        .start_i (scan_start),
        .step_i  (scan_step),
        .cx_o    (cx),
        .cy_o    (cy),
        .last_o  (last)
    );

    always_comb begin
        base_x  = (state_q == S_ERASE) ? prev_x_q : lat_x_q;
        base_y  = (state_q == S_ERASE) ? prev_y_q : lat_y_q;
        sum_x   = {1'b0, base_x} + 11'(cx);
        sum_y   = {1'b0, base_y} + 11'(cy);
        visible = (sum_x < 11'(SCREEN_W)) && (sum_y < 11'(SCREEN_H));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lat_x_q      <= '0;
            lat_y_q      <= '0;
            lat_alive_q  <= 1'b0;
            prev_x_q     <= '0;
            prev_y_q     <= '0;
            prev_valid_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            color_q      <= '0;
            we_q         <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.plot) begin
                        lat_x_q     <= bus.x_pos;
                        lat_y_q     <= bus.y_pos;
                        lat_alive_q <= bus.alive;
                        if (prev_valid_q)   state_q <= S_ERASE;
                        else if (bus.alive) state_q <= S_DRAW;
                        else                state_q <= S_DONE;
                    end
                end
                S_ERASE, S_DRAW: begin
                    // Clipped slots still take their cycle; only writeEn drops
                    we_q <= visible;
                    if (visible) begin
                        x_q     <= sum_x[9:0];
                        y_q     <= sum_y[9:0];
                        color_q <= (state_q == S_ERASE) ? BG_COLOR : SHOT_COLOR;
                    end
                    if (last) begin
                        if (state_q == S_ERASE && lat_alive_q) state_q <= S_DRAW;
                        else                                   state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q       <= 1'b1;
                    prev_x_q     <= lat_x_q;
                    prev_y_q     <= lat_y_q;
                    prev_valid_q <= lat_alive_q;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.color     = color_q;
    assign bus.writeEn   = we_q;
    assign bus.draw_done = done_q;

endmodule
